// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: synchronizes an asynchronous pad signal, debounces it,
// emits single-cycle rise/fall pulses and counts aborted transitions.
module pad_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_raw,
    input  logic                clr_glitch,
    output logic                a_clean,
    output logic                a_rise,
    output logic                a_fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW,
        PEND_HI,
        HIGH,
        PEND_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   a_sync;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   clean_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   glitch_inc;

    // Plain shift chain, no logic between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_raw};
        end
    end

    assign a_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOW;
            cnt     <= '0;
            a_clean <= 1'b0;
            a_rise  <= 1'b0;
            a_fall  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            a_clean <= clean_nxt;
            a_rise  <= rise_nxt;
            a_fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        clean_nxt  = a_clean;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_inc = 1'b0;
        case (state)
            LOW: begin
                if (a_sync) begin
                    state_nxt = PEND_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!a_sync) begin
                    state_nxt  = LOW;
                    cnt_nxt    = '0;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    clean_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!a_sync) begin
                    state_nxt = PEND_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (a_sync) begin
                    state_nxt  = HIGH;
                    cnt_nxt    = '0;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    clean_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Clear has priority over a same-cycle increment; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr_glitch) begin
            glitch_cnt <= '0;
        end else if (glitch_inc && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Randomized and directed bench for pad_input_conditioner, checked against a
// run-length reference model of the debounce rules.
module tb_pad_input_conditioner;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int GW = 8;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_raw = 1'b0;
    logic          clr_glitch = 1'b0;
    logic          a_clean;
    logic          a_rise;
    logic          a_fall;
    logic [GW-1:0] glitch_cnt;

    pad_input_conditioner #(
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D),
        .GLITCH_W(GW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .a_raw(a_raw),
        .clr_glitch(clr_glitch),
        .a_clean(a_clean),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state
    bit m_sh[S];
    bit m_clean, m_rise, m_fall;
    int m_run, m_gl;

    // Protocol trackers
    bit last_was_rise;
    int held;
    bit prev_clean;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit raw, input bit clr);
        bit as;
        if (rst) begin
            for (int i = 0; i < S; i++) m_sh[i] = 1'b0;
            m_clean = 0; m_rise = 0; m_fall = 0; m_run = 0; m_gl = 0;
            return;
        end
        as = m_sh[S-1];
        for (int i = S - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = raw;
        m_rise = 0;
        m_fall = 0;
        if (as != m_clean) begin
            m_run++;
            if (m_run == D) begin
                m_clean = as;
                m_rise = as;
                m_fall = !as;
                m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_gl < GMAX) m_gl++;
            m_run = 0;
        end
        if (clr) m_gl = 0;
    endtask

    task automatic step(input bit rst, input bit raw, input bit clr);
        reset = rst;
        a_raw = raw;
        clr_glitch = clr;
        @(posedge clk);
        model_edge(rst, raw, clr);
        cyc++;
        #1;
        check("a_clean", int'(a_clean), int'(m_clean));
        check("a_rise", int'(a_rise), int'(m_rise));
        check("a_fall", int'(a_fall), int'(m_fall));
        check("glitch_cnt", int'(glitch_cnt), m_gl);
        check("rise_fall_overlap", int'(a_rise & a_fall), 0);
        if (rst) begin
            last_was_rise = 0;
            held = 1000;
            prev_clean = 0;
        end else begin
            if (a_rise) begin
                check("alternate_rise", int'(last_was_rise), 0);
                last_was_rise = 1;
            end
            if (a_fall) begin
                check("alternate_fall", int'(last_was_rise), 1);
                last_was_rise = 0;
            end
            if (a_clean != prev_clean) begin
                check("min_hold", int'(held >= D), 1);
                held = 0;
            end
            held++;
            prev_clean = a_clean;
        end
    endtask

    task automatic wait_rise(input string tag, input int exp_edges);
        int t0;
        t0 = cyc;
        for (int i = 0; i < 20 && !(a_rise === 1'b1); i++) step(0, a_raw, 0);
        check(tag, cyc - t0, exp_edges);
    endtask

    task automatic wait_fall(input string tag, input int exp_edges);
        int t0;
        t0 = cyc;
        for (int i = 0; i < 20 && !(a_fall === 1'b1); i++) step(0, a_raw, 0);
        check(tag, cyc - t0, exp_edges);
    endtask

    initial begin
        // Reset with level held high, then a rise after full latency.
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        check("rst_clean", int'(a_clean), 0);
        check("rst_glitch", int'(glitch_cnt), 0);
        a_raw = 1'b1;
        wait_rise("rise_after_reset_edges", S + D);
        check("clean_after_reset", int'(a_clean), 1);

        // Clean rise and fall with 10-cycle holds.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        a_raw = 1'b1;
        wait_rise("rise_latency", S + D);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        a_raw = 1'b0;
        wait_fall("fall_latency", S + D);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check("no_glitch_clean", int'(glitch_cnt), 0);

        // Reset while pending high with cnt=2.
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check("rst_pend_clean", int'(a_clean), 0);
        check("rst_pend_glitch", int'(glitch_cnt), 0);

        // Single glitch, then saturation.
        step(0, 1, 0); step(0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check("one_glitch", int'(glitch_cnt), 1);
        check("glitch_no_clean", int'(a_clean), 0);
        for (int g = 0; g < 299; g++) begin
            step(0, 1, 0); step(0, 1, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0);
        end
        check("glitch_sat", int'(glitch_cnt), GMAX);

        // Clear coinciding with an aborted transition.
        step(0, 1, 0); step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("clr_beats_inc", int'(glitch_cnt), 0);

        // Random pad activity with occasional clears.
        begin
            bit lvl = 1'b0;
            int left = 0;
            for (int i = 0; i < 10000; i++) begin
                if (left == 0) begin
                    lvl = ~lvl;
                    left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                        : $urandom_range(1, 12);
                end
                left--;
                #($urandom_range(0, 3));
                step(0, lvl, $urandom_range(0, 199) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
